// File: rtl/four_input_toggle_gen_if.sv
// Control/stimulus bundle for four_input_toggle_gen: start/stop handshake, run length and
// generated waves. `mode` exists only when TOGGLE_GEN_LFSR_EN is defined.
interface four_input_toggle_gen_if;
  logic        start;
  logic        stop;
  logic [15:0] run_len;
`ifdef TOGGLE_GEN_LFSR_EN
  logic        mode;
`endif
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;

  modport master (
    output start, stop, run_len,
`ifdef TOGGLE_GEN_LFSR_EN
    output mode,
`endif
    input  a, b, c, d, busy, done
  );

  modport slave (
    input  start, stop, run_len,
`ifdef TOGGLE_GEN_LFSR_EN
    input  mode,
`endif
    output a, b, c, d, busy, done
  );
endinterface

// File: rtl/four_input_toggle_gen.sv
// Square-wave stimulus source for the a/b/c/d inputs of the four-input AND stage.
// Optional feature macro TOGGLE_GEN_LFSR_EN adds an LFSR pattern mode selected at start.
module four_input_toggle_gen #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned HALF_A = 100,
  parameter int unsigned HALF_B = 70,
  parameter int unsigned HALF_C = 50,
  parameter int unsigned HALF_D = 20
) (
  input logic                  clk,
  input logic                  rst_n,
  four_input_toggle_gen_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Index 3 drives a, index 0 drives d, matching {a,b,c,d} bit order.
  localparam logic [CNT_W-1:0] HalfM1 [4] = '{
    CNT_W'(HALF_D - 1), CNT_W'(HALF_C - 1), CNT_W'(HALF_B - 1), CNT_W'(HALF_A - 1)
  };

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [4];
  logic [CNT_W-1:0]  cnt_d [4];
  logic [3:0]        wave_q, wave_d;
  logic [15:0]       run_cnt_q, run_cnt_d;
  logic [15:0]       run_len_q, run_len_d;
  logic              run_last;

`ifdef TOGGLE_GEN_LFSR_EN
  logic              mode_q, mode_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              lfsr_fb;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
`endif

  assign run_last = (run_len_q != 16'd0) && (run_cnt_q == run_len_q - 16'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wave_d    = wave_q;
    run_cnt_d = run_cnt_q;
    run_len_d = run_len_q;
`ifdef TOGGLE_GEN_LFSR_EN
    mode_d    = mode_q;
    lfsr_d    = lfsr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.stop) begin
          state_d   = StRun;
          wave_d    = 4'b0000;
          run_cnt_d = 16'd0;
          run_len_d = bus.run_len;
          for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
          end
`ifdef TOGGLE_GEN_LFSR_EN
          mode_d = bus.mode;
          lfsr_d = 8'hA5;
`endif
        end
      end

      StRun: begin
        // Stop wins over completion; the final RUN edge leaves the waves untouched.
        if (bus.stop) begin
          state_d = StIdle;
        end else if (run_last) begin
          state_d = StDone;
        end else begin
          run_cnt_d = run_cnt_q + 16'd1;
          for (int i = 0; i < 4; i++) begin
            if (cnt_q[i] == HalfM1[i]) begin
              cnt_d[i]  = '0;
              wave_d[i] = ~wave_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
`ifdef TOGGLE_GEN_LFSR_EN
          if (mode_q) begin
            wave_d = lfsr_q[3:0];
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
          end
`endif
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '{default: '0};
      wave_q    <= 4'b0000;
      run_cnt_q <= 16'd0;
      run_len_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wave_q    <= wave_d;
      run_cnt_q <= run_cnt_d;
      run_len_q <= run_len_d;
    end
  end

`ifdef TOGGLE_GEN_LFSR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      lfsr_q <= 8'hA5;
    end else begin
      mode_q <= mode_d;
      lfsr_q <= lfsr_d;
    end
  end
`endif

  assign bus.a    = wave_q[3];
  assign bus.b    = wave_q[2];
  assign bus.c    = wave_q[1];
  assign bus.d    = wave_q[0];
  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);

endmodule

// File: tb/tb_four_input_toggle_gen.sv
// Self-checking bench for four_input_toggle_gen: directed scenarios plus randomized runs
// compared against an arithmetic model of the waveform timing.
module tb_four_input_toggle_gen;

  localparam int CNT_W  = 8;
  localparam int HALF_A = 100;
  localparam int HALF_B = 70;
  localparam int HALF_C = 50;
  localparam int HALF_D = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  four_input_toggle_gen_if bus ();

  four_input_toggle_gen #(
    .CNT_W  (CNT_W),
    .HALF_A (HALF_A),
    .HALF_B (HALF_B),
    .HALF_C (HALF_C),
    .HALF_D (HALF_D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] obs;
  assign obs = {bus.a, bus.b, bus.c, bus.d, bus.busy, bus.done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sq(int j, int h);
    return ((j / h) % 2) == 1;
  endfunction

  // Expected {a,b,c,d,busy,done} k edges after the start edge. stop_at is the edge at which
  // stop is seen (<1 = never); waves freeze at the last RUN edge.
  function automatic logic [5:0] exp_vec(int k, int len, int stop_at);
    logic bsy, dn;
    int   j;
    if (stop_at >= 1 && (len == 0 || stop_at <= len)) begin
      bsy = (k < stop_at);
      dn  = 1'b0;
      j   = (k < stop_at) ? k : stop_at - 1;
    end else if (len > 0) begin
      bsy = (k < len);
      dn  = (k == len);
      j   = (k < len) ? k : len - 1;
    end else begin
      bsy = 1'b1;
      dn  = 1'b0;
      j   = k;
    end
    return {sq(j, HALF_A), sq(j, HALF_B), sq(j, HALF_C), sq(j, HALF_D), bsy, dn};
  endfunction

  task automatic launch(input int len);
    bus.start   = 1'b1;
    bus.run_len = 16'(len);
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic test_reset();
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.run_len = 16'd0;
`ifdef TOGGLE_GEN_LFSR_EN
    bus.mode    = 1'b0;
`endif
    rst_n = 1'b0;
    #12;
    checks++;
    if (obs !== 6'b0) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=%b", obs, 6'b0);
    end
    rst_n = 1'b1;
    tick();
    launch(0);
    repeat (30) tick();
    checks++;
    if (obs !== exp_vec(30, 0, 0)) begin
      failures++;
      $display("FAIL reset_prerun got=%b exp=%b", obs, exp_vec(30, 0, 0));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b0) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", obs, 6'b0);
    end
    #3 rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs !== 6'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=%b", obs, 6'b0);
    end
  endtask

  task automatic test_free_run();
    launch(0);
    for (int k = 0; k < 260; k++) begin
      if (k > 0) tick();
      checks++;
      if (obs !== exp_vec(k, 0, 0)) begin
        failures++;
        $display("FAIL free_run k=%0d got=%b exp=%b", k, obs, exp_vec(k, 0, 0));
      end
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL free_run_stop busy=%b exp=0", bus.busy);
    end
    tick();
  endtask

  task automatic test_bounded();
    launch(200);
    for (int k = 0; k <= 205; k++) begin
      if (k > 0) tick();
      checks++;
      if (obs !== exp_vec(k, 200, 0)) begin
        failures++;
        $display("FAIL bounded k=%0d got=%b exp=%b", k, obs, exp_vec(k, 200, 0));
      end
    end
  endtask

  task automatic test_abort();
    launch(0);
    for (int k = 0; k <= 90; k++) begin
      if (k > 0) begin
        bus.stop = (k == 76);
        tick();
      end
      checks++;
      if (obs !== exp_vec(k, 0, 76)) begin
        failures++;
        $display("FAIL abort k=%0d got=%b exp=%b", k, obs, exp_vec(k, 0, 76));
      end
    end
    bus.stop = 1'b0;
    checks++;
    if (obs[5:2] !== 4'b0111) begin
      failures++;
      $display("FAIL abort_frozen got=%b exp=0111", obs[5:2]);
    end
  endtask

  task automatic test_collision();
    logic [5:0] held;
    held = exp_vec(90, 0, 76) & 6'b111100;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    bus.run_len = 16'd10;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs !== held) begin
        failures++;
        $display("FAIL collision_idle k=%0d got=%b exp=%b", k, obs, held);
      end
      tick();
    end
    launch(60);
    for (int k = 0; k <= 63; k++) begin
      if (k > 0) begin
        bus.start = (k == 30);
        tick();
      end
      checks++;
      if (obs !== exp_vec(k, 60, 0)) begin
        failures++;
        $display("FAIL collision_restart k=%0d got=%b exp=%b", k, obs, exp_vec(k, 60, 0));
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_back_to_back();
    launch(25);
    for (int k = 0; k <= 26; k++) begin
      if (k > 0) tick();
      checks++;
      if (obs !== exp_vec(k, 25, 0)) begin
        failures++;
        $display("FAIL b2b_first k=%0d got=%b exp=%b", k, obs, exp_vec(k, 25, 0));
      end
    end
    launch(40);
    for (int k = 0; k <= 42; k++) begin
      if (k > 0) tick();
      checks++;
      if (obs !== exp_vec(k, 40, 0)) begin
        failures++;
        $display("FAIL b2b_second k=%0d got=%b exp=%b", k, obs, exp_vec(k, 40, 0));
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int len, s, p, last, endk;
      len = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 300));
      if (len == 0) s = int'($urandom_range(1, 300));
      else s = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, len + 5));
      last = (s >= 1 && (len == 0 || s <= len)) ? s : len;
      p    = int'($urandom_range(1, last));
      endk = last + 3;
      repeat ($urandom_range(0, 3)) tick();
      launch(len);
      for (int k = 0; k <= endk; k++) begin
        if (k > 0) begin
          bus.stop  = (k == s);
          bus.start = (k == p);
          tick();
        end
        checks++;
        if (obs !== exp_vec(k, len, s)) begin
          failures++;
          $display("FAIL random it=%0d len=%0d stop=%0d k=%0d got=%b exp=%b",
                   it, len, s, k, obs, exp_vec(k, len, s));
        end
      end
      bus.stop  = 1'b0;
      bus.start = 1'b0;
    end
  endtask

`ifdef TOGGLE_GEN_LFSR_EN
  task automatic test_lfsr();
    logic [7:0] r;
    logic [3:0] seq [3];
    logic [3:0] e;
    r = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      seq[i] = r[3:0];
      r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    end
    bus.mode = 1'b1;
    launch(4);
    bus.mode = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      e = (k == 0) ? 4'b0000 : seq[(k < 4 ? k : 3) - 1];
      checks++;
      if (obs !== {e, k < 4, k == 4}) begin
        failures++;
        $display("FAIL lfsr k=%0d got=%b exp=%b", k, obs, {e, k < 4, k == 4});
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_bounded();
    test_abort();
    test_collision();
    test_back_to_back();
    test_random();
`ifdef TOGGLE_GEN_LFSR_EN
    test_lfsr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
